board_sync_mem: RTL and testbench
=================================

Name: board_sync_mem

Overview:
- Clocked, parametrised successor to the bench board memory model.
- Models an external memory on the core's multiplexed 16-bit bus with byte lanes.
- Address is captured in two latch phases.
- Adds programmable wait states, an explicit read strobe, a one-cycle ready pulse, and optional address auto-increment for sequential bursts.
- Sits in the bench between the core's external bus interface and the testbench.

Parameters:
- DW, 16, data/latch width; must be even; the byte lanes are DW/2 each.
- SIZE, 8, memory index bits; depth is 2^SIZE words of DW bits.
- WAIT, 2, wait-state cycles between request acceptance and completion; 0 is legal.
- INCR, 1, 1 = auto-increment the word index after each completed transfer; 0 = fixed address.

Ports:
- clk  input  1  bench clock; all state changes on its rising edge.
- reset  input  1  synchronous reset, active-low; sampled on rising clk.
- inp  input  DW  multiplexed address/write-data bus.
- le  input  2  address latch enables, active-high; le[0] loads a0, le[1] loads a1.
- bhe  input  1  byte-high enable, active-low.
- we  input  1  write request, active-low.
- re  input  1  read request, active-low.
- out  output  DW  read data, registered.
- rdy  output  1  one-cycle completion pulse.
- busy  output  1  high in WAIT or DONE.
- wr_count  output  16  number of committed writes, wraps at 2^16.

Behaviour:
- Address register: addr = {a1, a0}, 2*DW bits.
  - ce = !addr[2*DW-3]; this is bit 29 for DW=16.
  - ble = addr[2*DW-1]; this is bit 31, active-low low-byte enable.
  - Word index idx = a0[SIZE-1:0].
- Latching: a0 <= inp on a clock where le[0]=1; a1 <= inp on a clock where le[1]=1. Both may load in the same cycle. Latching happens only in IDLE and HOLD; le is ignored in WAIT and DONE.
- Reset (reset=0 at clk edge):
  - state=IDLE; a0=a1=0; out=0; rdy=0; busy=0; wr_count=0.
  - Memory contents are not cleared.
  - Reset during WAIT or DONE aborts the transfer with no memory write.
- FSM states: IDLE, WAIT, DONE, HOLD.
- IDLE -> on a cycle with le==0, ce=1 and (we=0 or re=0):
  - Capture the request type. Write wins if both we and re are low.
  - Capture idx, the lane enables (!ble, !bhe), and write data = inp.
  - Load the wait counter with WAIT.
  - Go to WAIT, or directly to DONE if WAIT=0.
  - With ce=0, requests are ignored and the block stays IDLE.
- WAIT: decrement the counter each cycle; go to DONE on the cycle the counter reaches 0. Bus inputs are not resampled.
- DONE, one cycle:
  - rdy=1.
  - Write: update each enabled byte lane of mem[idx] from the captured data; a lane whose enable is high (not enabled) keeps its old value; wr_count+1 even if both lanes are disabled.
  - Read: out <= mem[idx], visible from the cycle after DONE and held until the next read completes.
  - Go to HOLD.
- HOLD: wait until we=1 and re=1. On that cycle:
  - If INCR=1, a0[SIZE-1:0] <= idx+1 modulo 2^SIZE; the upper bits of a0 and all of a1 are unchanged (no carry).
  - Go to IDLE.
  - A simultaneous le during this HOLD-exit cycle wins over the increment for the loaded half.
- Request latency: the accepting edge plus WAIT cycles, then rdy on the following cycle. A new request needs at least one cycle with we=re=1 between transfers.
- rdy is never high in two consecutive cycles.
- busy=1 exactly in WAIT and DONE.

Test Plan:
- Reset, then le[0]=1 inp=0x0005, then le[1]=1 inp=0x0000, then we=0 bhe=0 inp=0xBEEF, WAIT=2 -> rdy pulses 3 cycles after acceptance, mem[5]=0xBEEF, wr_count=1.
- Read back: with the same address latched, re=0 -> rdy after WAIT+1 cycles, out=0xBEEF the next cycle and held after re releases.
- Byte lanes: a1=0x8000 (ble=1), bhe=0, write 0x1234 over 0xBEEF -> mem=0x12EF. With a1=0x0000, bhe=1, write 0x5678 -> mem=0x1278.
- Burst/wrap: INCR=1, a0=0x00FF, SIZE=8, three writes 0x0A, 0x0B, 0x0C separated by idle cycles -> mem[0xFF]=0x0A, mem[0x00]=0x0B, mem[0x01]=0x0C; a0 upper byte unchanged.
- Chip deselect and priority: a1=0x2000 with we=0 -> no rdy and no write. Then a1=0, we=0 and re=0 together -> a write occurs and out is unchanged.
- Reset mid-transfer: WAIT=4, assert reset=0 in the 2nd WAIT cycle -> no memory change, rdy never pulses, state IDLE, wr_count=0. WAIT=0 variant -> rdy on the cycle after acceptance.

Source files
------------

// File: rtl/board_sync_mem.sv
// board_sync_mem: clocked external-memory model for a multiplexed 16-bit
// bus with byte lanes. The address is latched in two phases. Transfers have
// programmable wait states and end with a one-cycle ready pulse.
// The word index can auto-increment for sequential bursts.
module board_sync_mem #(
    parameter int unsigned DW   = 16,
    parameter int unsigned SIZE = 8,
    parameter int unsigned WAIT = 2,
    parameter int unsigned INCR = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] inp,
    input  logic [1:0]    le,
    input  logic          bhe,
    input  logic          we,
    input  logic          re,
    output logic [DW-1:0] out,
    output logic          rdy,
    output logic          busy,
    output logic [15:0]   wr_count
);

    localparam int unsigned H     = DW / 2;
    localparam int unsigned DEPTH = 1 << SIZE;
    localparam int unsigned CW    = (WAIT < 2) ? 1 : $clog2(WAIT + 1);
    localparam bit          NO_WAIT = (WAIT == 0);
    localparam bit          DO_INCR = (INCR != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Only the decoded bits of {a1,a0} are held; the other bits never
    // affect behaviour. a1_ble is addr[2*DW-1], a1_cen is addr[2*DW-3].
    logic [SIZE-1:0] a0_idx;
    logic            a1_ble;
    logic            a1_cen;
    logic            ce;

    logic [CW-1:0]   cnt;
    logic            accept;
    logic            cap_wr;
    logic [SIZE-1:0] cap_idx;
    logic            cap_lo;
    logic            cap_hi;
    logic [DW-1:0]   cap_data;

    logic [DW-1:0]   mem [DEPTH];

    assign ce = !a1_cen;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and request acceptance
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (le == 2'b00 && ce && (!we || !re)) begin
                    accept    = 1'b1;
                    state_nxt = NO_WAIT ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: if (cnt == CW'(1)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_HOLD;
            S_HOLD: if (we && re) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address latches, request capture, wait counter and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            a0_idx   <= '0;
            a1_ble   <= 1'b0;
            a1_cen   <= 1'b0;
            cnt      <= '0;
            cap_wr   <= 1'b0;
            cap_idx  <= '0;
            cap_lo   <= 1'b0;
            cap_hi   <= 1'b0;
            cap_data <= '0;
            out      <= '0;
            rdy      <= 1'b0;
            busy     <= 1'b0;
            wr_count <= '0;
        end else begin
            rdy  <= (state_nxt == S_DONE);
            busy <= (state_nxt == S_WAIT) || (state_nxt == S_DONE);

            if (state == S_IDLE || state == S_HOLD) begin
                // A same-cycle le load overrides the burst increment.
                if (DO_INCR && state == S_HOLD && state_nxt == S_IDLE)
                    a0_idx <= cap_idx + SIZE'(1);
                if (le[0]) a0_idx <= inp[SIZE-1:0];
                if (le[1]) begin
                    a1_ble <= inp[DW-1];
                    a1_cen <= inp[DW-3];
                end
            end

            if (accept) begin
                cap_wr   <= !we;
                cap_idx  <= a0_idx;
                cap_lo   <= !a1_ble;
                cap_hi   <= !bhe;
                cap_data <= inp;
                cnt      <= CW'(WAIT);
            end else if (state == S_WAIT) begin
                cnt <= cnt - CW'(1);
            end

            if (state == S_DONE) begin
                if (cap_wr) wr_count <= wr_count + 16'd1;
                else        out      <= mem[cap_idx];
            end
        end
    end

    // Byte-lane memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (reset && state == S_DONE && cap_wr) begin
            if (cap_lo) mem[cap_idx][H-1:0]  <= cap_data[H-1:0];
            if (cap_hi) mem[cap_idx][DW-1:H] <= cap_data[DW-1:H];
        end
    end

endmodule

// File: tb/tb_board_sync_mem.sv
// Directed bench for board_sync_mem: three instances (WAIT=2, 4 and 0)
// share one bus; each has its own reset so only one is active at a time.
module tb_board_sync_mem;

    logic        clk = 1'b0;
    logic        rst_m, rst_4, rst_0;
    logic [15:0] inp;
    logic [1:0]  le;
    logic        bhe, we, re;

    logic [15:0] out_m, out_4, out_0;
    logic        rdy_m, rdy_4, rdy_0;
    logic        busy_m, busy_4, busy_0;
    logic [15:0] wc_m, wc_4, wc_0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    board_sync_mem #(.DW(16), .SIZE(8), .WAIT(2), .INCR(1)) dut (
        .clk(clk), .reset(rst_m), .inp(inp), .le(le), .bhe(bhe), .we(we), .re(re),
        .out(out_m), .rdy(rdy_m), .busy(busy_m), .wr_count(wc_m));

    board_sync_mem #(.DW(16), .SIZE(8), .WAIT(4), .INCR(1)) dut4 (
        .clk(clk), .reset(rst_4), .inp(inp), .le(le), .bhe(bhe), .we(we), .re(re),
        .out(out_4), .rdy(rdy_4), .busy(busy_4), .wr_count(wc_4));

    board_sync_mem #(.DW(16), .SIZE(8), .WAIT(0), .INCR(1)) dut0 (
        .clk(clk), .reset(rst_0), .inp(inp), .le(le), .bhe(bhe), .we(we), .re(re),
        .out(out_0), .rdy(rdy_0), .busy(busy_0), .wr_count(wc_0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_rdy(input int sel);
        return (sel == 0) ? rdy_m : (sel == 1) ? rdy_4 : rdy_0;
    endfunction

    function automatic logic cur_busy(input int sel);
        return (sel == 0) ? busy_m : (sel == 1) ? busy_4 : busy_0;
    endfunction

    task automatic bus_idle();
        le = 2'b00; we = 1'b1; re = 1'b1; bhe = 1'b1; inp = 16'h0000;
    endtask

    task automatic latch(input logic [15:0] a0v, input logic [15:0] a1v);
        le = 2'b01; inp = a0v; tick();
        le = 2'b10; inp = a1v; tick();
        bus_idle();
    endtask

    // One transfer: accept, wait (bounded) for rdy, step into HOLD, exit to IDLE.
    task automatic xfer(input int sel, input logic w, input logic r, input logic b,
                        input logic [15:0] d, output int lat, output logic busy_acc,
                        output logic rdy_nxt, output logic busy_nxt);
        le = 2'b00; we = w; re = r; bhe = b; inp = d;
        tick();
        bus_idle();
        busy_acc = cur_busy(sel);
        lat = 1;
        while (cur_rdy(sel) !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        rdy_nxt  = cur_rdy(sel);
        busy_nxt = cur_busy(sel);
        tick();
    endtask

    task automatic test_reset();
        rst_m = 1'b0; rst_4 = 1'b0; rst_0 = 1'b0;
        bus_idle();
        tick(); tick();
        total++; if (out_m !== 16'h0000) $display("FAIL reset_out got %h want 0000", out_m); else passed++;
        total++; if (rdy_m !== 1'b0) $display("FAIL reset_rdy got %b want 0", rdy_m); else passed++;
        total++; if (busy_m !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_m); else passed++;
        total++; if (wc_m !== 16'd0) $display("FAIL reset_wr_count got %0d want 0", wc_m); else passed++;
        rst_m = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int lat; logic ba, rn, bn;
        latch(16'h0005, 16'h0000);
        xfer(0, 1'b0, 1'b1, 1'b0, 16'hBEEF, lat, ba, rn, bn);
        total++; if (ba !== 1'b1) $display("FAIL write_busy_wait got %b want 1", ba); else passed++;
        total++; if (lat !== 3) $display("FAIL write_latency got %0d want 3", lat); else passed++;
        total++; if (rn !== 1'b0) $display("FAIL write_rdy_single got %b want 0", rn); else passed++;
        total++; if (bn !== 1'b0) $display("FAIL write_busy_hold got %b want 0", bn); else passed++;
        total++; if (wc_m !== 16'd1) $display("FAIL write_wr_count got %0d want 1", wc_m); else passed++;
    endtask

    task automatic test_read();
        int lat; logic ba, rn, bn;
        latch(16'h0005, 16'h0000);
        xfer(0, 1'b1, 1'b0, 1'b1, 16'h0000, lat, ba, rn, bn);
        total++; if (lat !== 3) $display("FAIL read_latency got %0d want 3", lat); else passed++;
        total++; if (out_m !== 16'hBEEF) $display("FAIL read_data got %h want BEEF", out_m); else passed++;
        tick(); tick();
        total++; if (out_m !== 16'hBEEF) $display("FAIL read_hold got %h want BEEF", out_m); else passed++;
        total++; if (wc_m !== 16'd1) $display("FAIL read_no_count got %0d want 1", wc_m); else passed++;
    endtask

    task automatic test_lanes();
        int lat; logic ba, rn, bn;
        latch(16'h0005, 16'h8000);
        xfer(0, 1'b0, 1'b1, 1'b0, 16'h1234, lat, ba, rn, bn);
        latch(16'h0005, 16'h0000);
        xfer(0, 1'b1, 1'b0, 1'b1, 16'h0000, lat, ba, rn, bn);
        total++; if (out_m !== 16'h12EF) $display("FAIL lane_high_only got %h want 12EF", out_m); else passed++;
        latch(16'h0005, 16'h0000);
        xfer(0, 1'b0, 1'b1, 1'b1, 16'h5678, lat, ba, rn, bn);
        latch(16'h0005, 16'h0000);
        xfer(0, 1'b1, 1'b0, 1'b1, 16'h0000, lat, ba, rn, bn);
        total++; if (out_m !== 16'h1278) $display("FAIL lane_low_only got %h want 1278", out_m); else passed++;
        total++; if (wc_m !== 16'd3) $display("FAIL lane_wr_count got %0d want 3", wc_m); else passed++;
    endtask

    task automatic test_burst();
        int lat; logic ba, rn, bn;
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h000A; exp_d[1] = 16'h000B; exp_d[2] = 16'h000C;
        latch(16'h00FF, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b0, 1'b1, 1'b0, exp_d[i], lat, ba, rn, bn);
            tick();
        end
        total++; if (wc_m !== 16'd6) $display("FAIL burst_wr_count got %0d want 6", wc_m); else passed++;
        latch(16'h00FF, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b1, 1'b0, 1'b1, 16'h0000, lat, ba, rn, bn);
            total++;
            if (out_m !== exp_d[i]) $display("FAIL burst_read_%0d got %h want %h", i, out_m, exp_d[i]);
            else passed++;
        end
    endtask

    task automatic test_deselect_priority();
        int lat; logic ba, rn, bn; logic saw_rdy, saw_busy;
        latch(16'h0005, 16'h2000);
        saw_rdy = 1'b0; saw_busy = 1'b0;
        we = 1'b0; bhe = 1'b0; inp = 16'hDEAD;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rdy_m === 1'b1) saw_rdy = 1'b1;
            if (busy_m === 1'b1) saw_busy = 1'b1;
        end
        bus_idle();
        tick();
        total++; if (saw_rdy !== 1'b0) $display("FAIL deselect_rdy got %b want 0", saw_rdy); else passed++;
        total++; if (saw_busy !== 1'b0) $display("FAIL deselect_busy got %b want 0", saw_busy); else passed++;
        total++; if (wc_m !== 16'd6) $display("FAIL deselect_wr_count got %0d want 6", wc_m); else passed++;
        latch(16'h0005, 16'h0000);
        xfer(0, 1'b0, 1'b0, 1'b0, 16'h4321, lat, ba, rn, bn);
        total++; if (wc_m !== 16'd7) $display("FAIL priority_wr_count got %0d want 7", wc_m); else passed++;
        total++; if (out_m !== 16'h000C) $display("FAIL priority_out_kept got %h want 000C", out_m); else passed++;
        latch(16'h0005, 16'h0000);
        xfer(0, 1'b1, 1'b0, 1'b1, 16'h0000, lat, ba, rn, bn);
        total++; if (out_m !== 16'h4321) $display("FAIL priority_readback got %h want 4321", out_m); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat; logic ba, rn, bn; logic saw_rdy;
        rst_m = 1'b0; rst_4 = 1'b1;
        tick();
        latch(16'h0005, 16'h0000);
        xfer(1, 1'b0, 1'b1, 1'b0, 16'h1111, lat, ba, rn, bn);
        total++; if (lat !== 5) $display("FAIL wait4_latency got %0d want 5", lat); else passed++;
        latch(16'h0005, 16'h0000);
        we = 1'b0; bhe = 1'b0; inp = 16'h2222;
        tick();
        bus_idle();
        tick();
        rst_4 = 1'b0;
        saw_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rdy_4 === 1'b1) saw_rdy = 1'b1;
        end
        total++; if (saw_rdy !== 1'b0) $display("FAIL abort_rdy got %b want 0", saw_rdy); else passed++;
        total++; if (busy_4 !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_4); else passed++;
        total++; if (wc_4 !== 16'd0) $display("FAIL abort_wr_count got %0d want 0", wc_4); else passed++;
        rst_4 = 1'b1;
        tick();
        latch(16'h0005, 16'h0000);
        xfer(1, 1'b1, 1'b0, 1'b1, 16'h0000, lat, ba, rn, bn);
        total++; if (out_4 !== 16'h1111) $display("FAIL abort_mem_kept got %h want 1111", out_4); else passed++;
        total++; if (wc_4 !== 16'd0) $display("FAIL abort_read_count got %0d want 0", wc_4); else passed++;
        rst_4 = 1'b0;
    endtask

    task automatic test_wait0();
        int lat; logic ba, rn, bn;
        rst_0 = 1'b1;
        tick();
        latch(16'h0005, 16'h0000);
        xfer(2, 1'b0, 1'b1, 1'b0, 16'h0F0F, lat, ba, rn, bn);
        total++; if (lat !== 1) $display("FAIL wait0_latency got %0d want 1", lat); else passed++;
        total++; if (ba !== 1'b1) $display("FAIL wait0_busy_done got %b want 1", ba); else passed++;
        total++; if (rn !== 1'b0) $display("FAIL wait0_rdy_single got %b want 0", rn); else passed++;
        total++; if (wc_0 !== 16'd1) $display("FAIL wait0_wr_count got %0d want 1", wc_0); else passed++;
        latch(16'h0005, 16'h0000);
        xfer(2, 1'b1, 1'b0, 1'b1, 16'h0000, lat, ba, rn, bn);
        total++; if (out_0 !== 16'h0F0F) $display("FAIL wait0_readback got %h want 0F0F", out_0); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_lanes();
        test_burst();
        test_deselect_priority();
        test_reset_mid();
        test_wait0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
